// File: rtl/watch_core_gen2.sv
// rtl/watch_core_gen2.sv - 24h timekeeping core with 12h display, one alarm and a stopwatch
// Three raw buttons are synchronised and debounced before they drive the mode FSM.
module watch_core_gen2 #(
  parameter int TICK_DIV     = 10000000,
  parameter int DEBOUNCE_CYC = 200000,
  parameter int ALARM_LEN_S  = 30,
  parameter int SW_W         = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            btn_mode_i,
  input  logic            btn_set_i,
  input  logic            btn_inc_i,
  input  logic            fmt12_i,
  output logic [4:0]      disp_hour_o,
  output logic [5:0]      disp_min_o,
  output logic [5:0]      disp_sec_o,
  output logic            pm_o,
  output logic [2:0]      mode_o,
  output logic            alarm_en_o,
  output logic            alarm_o,
  output logic            sw_run_o,
  output logic [SW_W-1:0] sw_count_o,
  output logic            tick_o
);

  typedef enum logic [2:0] {
    M_TIME      = 3'd0,
    M_SET_HOUR  = 3'd1,
    M_SET_MIN   = 3'd2,
    M_AL_HOUR   = 3'd3,
    M_AL_MIN    = 3'd4,
    M_STOPWATCH = 3'd5
  } mode_e;

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam int AW = $clog2(ALARM_LEN_S + 1);
  localparam logic [AW-1:0] AL_LEN = AW'(ALARM_LEN_S);

  function automatic logic [4:0] inc_hour(input logic [4:0] h);
    return (h == 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] inc_min(input logic [5:0] m);
    return (m == 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      M_TIME:      return M_SET_HOUR;
      M_SET_HOUR:  return M_SET_MIN;
      M_SET_MIN:   return M_AL_HOUR;
      M_AL_HOUR:   return M_AL_MIN;
      M_AL_MIN:    return M_STOPWATCH;
      default:     return M_TIME;
    endcase
  endfunction

  logic [PW-1:0] presc_q;
  logic          tick;

  assign tick   = (presc_q == PRESC_LAST);
  assign tick_o = tick;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)  presc_q <= '0;
    else if (tick)   presc_q <= '0;
    else             presc_q <= presc_q + PW'(1);
  end

  // Bit 0 = mode, bit 1 = set, bit 2 = inc throughout the button path.
  logic [2:0]    btn_raw, sync1_q, sync2_q, db_q, db_prev_q, press;
  logic [DW-1:0] db_cnt_q [3];
  logic          ev_mode, ev_set, ev_inc;

  assign btn_raw = {btn_inc_i, btn_set_i, btn_mode_i};

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != db_q[i]) begin
          if (db_cnt_q[i] == DB_LAST) begin
            db_q[i]     <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  // A mode press swallows any set/inc press landing in the same cycle.
  assign press   = db_q & ~db_prev_q;
  assign ev_mode = press[0];
  assign ev_set  = press[1] & ~press[0];
  assign ev_inc  = press[2] & ~press[0];

  mode_e           mode_q;
  logic [4:0]      hour_q, al_hour_q, hour_nx;
  logic [5:0]      min_q, sec_q, al_min_q, min_nx, sec_nx;
  logic            al_en_q, alarm_q, sw_run_q;
  logic [AW-1:0]   al_left_q;
  logic [SW_W-1:0] sw_cnt_q;
  logic            time_run, al_hit;

  always_comb begin
    sec_nx  = sec_q + 6'd1;
    min_nx  = min_q;
    hour_nx = hour_q;
    if (sec_q == 6'd59) begin
      sec_nx = 6'd0;
      min_nx = inc_min(min_q);
      if (min_q == 6'd59) hour_nx = inc_hour(hour_q);
    end
  end

  // Time is frozen while setting, including the edge that enters SET_HOUR.
  assign time_run = tick && (mode_q != M_SET_HOUR) && (mode_q != M_SET_MIN)
                    && !(ev_mode && (mode_q == M_TIME));
  assign al_hit   = time_run && al_en_q && (sec_nx == 6'd0)
                    && (min_nx == al_min_q) && (hour_nx == al_hour_q);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      mode_q    <= M_TIME;
      hour_q    <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      al_hour_q <= '0;
      al_min_q  <= '0;
      al_en_q   <= 1'b0;
      alarm_q   <= 1'b0;
      al_left_q <= '0;
      sw_run_q  <= 1'b0;
      sw_cnt_q  <= '0;
    end else begin
      if (time_run) begin
        sec_q  <= sec_nx;
        min_q  <= min_nx;
        hour_q <= hour_nx;
      end
      if (tick && sw_run_q && (sw_cnt_q != {SW_W{1'b1}})) sw_cnt_q <= sw_cnt_q + SW_W'(1);
      if (tick && alarm_q) begin
        if (al_left_q == AW'(1)) alarm_q <= 1'b0;
        else                     al_left_q <= al_left_q - AW'(1);
      end
      if (al_hit) begin
        alarm_q   <= 1'b1;
        al_left_q <= AL_LEN;
      end
      // Button actions come last so silencing/disarming beats a same-cycle trigger.
      if (ev_mode) begin
        if (mode_q == M_TIME) sec_q <= '0;
        mode_q <= next_mode(mode_q);
      end else begin
        case (mode_q)
          M_TIME:     if (ev_set) alarm_q <= 1'b0;
          M_SET_HOUR: if (ev_inc) hour_q <= inc_hour(hour_q);
          M_SET_MIN:  if (ev_inc) min_q <= inc_min(min_q);
          M_AL_HOUR, M_AL_MIN: begin
            if (ev_inc && (mode_q == M_AL_HOUR)) al_hour_q <= inc_hour(al_hour_q);
            if (ev_inc && (mode_q == M_AL_MIN))  al_min_q  <= inc_min(al_min_q);
            if (ev_set) begin
              al_en_q <= ~al_en_q;
              if (al_en_q) alarm_q <= 1'b0;
            end
          end
          M_STOPWATCH: begin
            if (ev_set) sw_run_q <= ~sw_run_q;
            if (ev_inc && !sw_run_q) sw_cnt_q <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign mode_o     = mode_q;
  assign alarm_en_o = al_en_q;
  assign alarm_o    = alarm_q;
  assign sw_run_o   = sw_run_q;
  assign sw_count_o = sw_cnt_q;

  logic [4:0] hour_src;
  logic       show_alarm;

  assign show_alarm = (mode_q == M_AL_HOUR) || (mode_q == M_AL_MIN);
  assign hour_src   = show_alarm ? al_hour_q : hour_q;
  assign disp_min_o = show_alarm ? al_min_q : min_q;
  assign disp_sec_o = show_alarm ? 6'd0 : sec_q;

  always_comb begin
    disp_hour_o = hour_src;
    pm_o        = 1'b0;
    if (fmt12_i) begin
      if (hour_src == 5'd0) begin
        disp_hour_o = 5'd12;
      end else if (hour_src == 5'd12) begin
        pm_o = 1'b1;
      end else if (hour_src > 5'd12) begin
        disp_hour_o = hour_src - 5'd12;
        pm_o        = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_watch_core_gen2.sv
// tb/tb_watch_core_gen2.sv - randomized and directed bench for watch_core_gen2
// Reference model keeps time as seconds-of-day and debounce as a sample window.
module tb_watch_core_gen2;

  localparam int TD    = 4;
  localparam int DEB   = 4;
  localparam int ALEN  = 3;
  localparam int SWW   = 4;
  localparam int SWMAX = 15;

  logic clk = 1'b0;
  logic rst_n, b_mode, b_set, b_inc, fmt12;
  logic [4:0] disp_hour_o;
  logic [5:0] disp_min_o, disp_sec_o;
  logic pm_o, alarm_en_o, alarm_o, sw_run_o, tick_o;
  logic [2:0] mode_o;
  logic [SWW-1:0] sw_count_o;

  int total = 0;
  int bad   = 0;

  watch_core_gen2 #(.TICK_DIV(TD), .DEBOUNCE_CYC(DEB), .ALARM_LEN_S(ALEN), .SW_W(SWW)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .btn_mode_i(b_mode), .btn_set_i(b_set),
    .btn_inc_i(b_inc), .fmt12_i(fmt12), .disp_hour_o(disp_hour_o), .disp_min_o(disp_min_o),
    .disp_sec_o(disp_sec_o), .pm_o(pm_o), .mode_o(mode_o), .alarm_en_o(alarm_en_o),
    .alarm_o(alarm_o), .sw_run_o(sw_run_o), .sw_count_o(sw_count_o), .tick_o(tick_o)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int m_ecount, m_tod, m_al, m_al_en, m_ring, m_left, m_run, m_sw, m_mode;
  int m_rose [3];
  int m_db   [3];
  int m_nv   [3];
  logic m_sa [3];
  logic m_sb [3];
  logic [DEB-1:0] m_win [3];

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ecount = 0; m_tod = 0; m_al = 0; m_al_en = 0; m_ring = 0; m_left = 0;
    m_run = 0; m_sw = 0; m_mode = 0;
    for (int b = 0; b < 3; b++) begin
      m_rose[b] = 0; m_db[b] = 0; m_nv[b] = 0; m_sa[b] = 0; m_sb[b] = 0; m_win[b] = '0;
    end
  endtask

  task automatic model_step();
    int t, em, es, ei, h, mi, s, run_old;
    logic raw [3];
    logic smp;
    logic [DEB-1:0] away;
    if (!rst_n) begin
      model_reset();
    end else begin
      t = ((m_ecount % TD) == TD - 1) ? 1 : 0;
      m_ecount++;
      em = m_rose[0];
      es = (m_rose[1] != 0 && em == 0) ? 1 : 0;
      ei = (m_rose[2] != 0 && em == 0) ? 1 : 0;
      run_old = m_run;
      if (t != 0 && m_ring != 0) begin
        m_left--;
        if (m_left == 0) m_ring = 0;
      end
      if (t != 0 && !(m_mode == 1 || m_mode == 2 || (em != 0 && m_mode == 0))) begin
        m_tod = (m_tod + 1) % 86400;
        if (m_al_en != 0 && m_tod == m_al * 60) begin
          m_ring = 1;
          m_left = ALEN;
        end
      end
      if (t != 0 && run_old != 0 && m_sw < SWMAX) m_sw++;
      h = m_tod / 3600; mi = (m_tod / 60) % 60; s = m_tod % 60;
      if (em != 0) begin
        if (m_mode == 0) m_tod = m_tod - s;
        m_mode = (m_mode + 1) % 6;
      end else begin
        case (m_mode)
          0: if (es != 0) m_ring = 0;
          1: if (ei != 0) m_tod = ((h + 1) % 24) * 3600 + mi * 60 + s;
          2: if (ei != 0) m_tod = h * 3600 + ((mi + 1) % 60) * 60 + s;
          3, 4: begin
            if (ei != 0 && m_mode == 3) m_al = (((m_al / 60) + 1) % 24) * 60 + m_al % 60;
            if (ei != 0 && m_mode == 4) m_al = (m_al / 60) * 60 + ((m_al % 60) + 1) % 60;
            if (es != 0) begin
              m_al_en = 1 - m_al_en;
              if (m_al_en == 0) m_ring = 0;
            end
          end
          default: begin
            if (es != 0) m_run = 1 - m_run;
            if (ei != 0 && run_old == 0) m_sw = 0;
          end
        endcase
      end
      raw[0] = b_mode; raw[1] = b_set; raw[2] = b_inc;
      for (int b = 0; b < 3; b++) begin
        smp = m_sb[b];
        m_sb[b] = m_sa[b];
        m_sa[b] = raw[b];
        m_win[b] = {m_win[b][DEB-2:0], smp};
        if (m_nv[b] < DEB) m_nv[b]++;
        away = (m_db[b] != 0) ? '0 : '1;
        m_rose[b] = 0;
        if (m_nv[b] == DEB && m_win[b] == away) begin
          m_db[b] = 1 - m_db[b];
          m_rose[b] = m_db[b];
        end
      end
    end
  endtask

  task automatic compare_all();
    int eh, emi, esec, pm;
    if (m_mode == 3 || m_mode == 4) begin
      eh = m_al / 60; emi = m_al % 60; esec = 0;
    end else begin
      eh = m_tod / 3600; emi = (m_tod / 60) % 60; esec = m_tod % 60;
    end
    pm = 0;
    if (fmt12) begin
      pm = (eh >= 12) ? 1 : 0;
      eh = (eh % 12 == 0) ? 12 : eh % 12;
    end
    chk("disp_hour", 32'(disp_hour_o), eh);
    chk("disp_min", 32'(disp_min_o), emi);
    chk("disp_sec", 32'(disp_sec_o), esec);
    chk("pm", 32'(pm_o), pm);
    chk("mode", 32'(mode_o), m_mode);
    chk("alarm_en", 32'(alarm_en_o), m_al_en);
    chk("alarm", 32'(alarm_o), m_ring);
    chk("sw_run", 32'(sw_run_o), m_run);
    chk("sw_count", 32'(sw_count_o), m_sw);
    chk("tick", 32'(tick_o), ((m_ecount % TD) == TD - 1) ? 1 : 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic press(input logic bm, input logic bs, input logic bi, input int hold, input int rel);
    b_mode = bm; b_set = bs; b_inc = bi;
    repeat (hold) cyc();
    b_mode = 1'b0; b_set = 1'b0; b_inc = 1'b0;
    repeat (rel) cyc();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; b_mode = 1'b0; b_set = 1'b0; b_inc = 1'b0; fmt12 = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all();
    chk("reset_mode", 32'(mode_o), 0);
    chk("reset_hour", 32'(disp_hour_o), 0);
    chk("reset_sw", 32'(sw_count_o), 0);
    rst_n = 1'b1;

    // Rollover from 23:59 set by buttons
    press(1, 0, 0, 7, 7);
    repeat (23) press(0, 0, 1, 7, 7);
    chk("set_hour23", 32'(disp_hour_o), 23);
    press(1, 0, 0, 7, 7);
    repeat (59) press(0, 0, 1, 7, 7);
    chk("set_min59", 32'(disp_min_o), 59);
    chk("set_sec0", 32'(disp_sec_o), 0);
    repeat (4) press(1, 0, 0, 7, 7);
    chk("back_to_time", 32'(mode_o), 0);
    n = 0;
    while (m_tod != 0 && n < 2000) begin cyc(); n++; end
    chk("rollover_reached", 32'(n < 2000), 1);
    chk("roll_hour", 32'(disp_hour_o), 0);
    chk("roll_min", 32'(disp_min_o), 0);
    chk("roll_sec", 32'(disp_sec_o), 0);
    chk("roll_pm", 32'(pm_o), 0);
    repeat (TD) cyc();
    chk("roll_next_sec", 32'(disp_sec_o), 1);

    // Debounce
    press(1, 0, 0, 2, 8);
    chk("short_press_ignored", 32'(mode_o), 0);
    press(1, 0, 0, 10, 8);
    chk("long_press_once", 32'(mode_o), 1);
    press(1, 0, 1, 7, 7);
    chk("mode_wins", 32'(mode_o), 2);
    chk("mode_wins_hour", 32'(disp_hour_o), 0);
    chk("sethour_sec_clear", 32'(disp_sec_o), 0);

    // 12h format
    repeat (5) press(1, 0, 0, 7, 7);
    repeat (13) press(0, 0, 1, 7, 7);
    fmt12 = 1'b1;
    cyc();
    chk("h13_12h", 32'(disp_hour_o), 1);
    chk("h13_pm", 32'(pm_o), 1);
    repeat (11) press(0, 0, 1, 7, 7);
    chk("h0_12h", 32'(disp_hour_o), 12);
    chk("h0_pm", 32'(pm_o), 0);
    repeat (12) press(0, 0, 1, 7, 7);
    chk("h12_12h", 32'(disp_hour_o), 12);
    chk("h12_pm", 32'(pm_o), 1);
    press(0, 0, 1, 7, 7);
    fmt12 = 1'b0;
    cyc();
    chk("h13_24h", 32'(disp_hour_o), 13);
    chk("h13_24h_pm", 32'(pm_o), 0);

    // Alarm with timeout
    repeat (11) press(0, 0, 1, 7, 7);
    press(1, 0, 0, 7, 7);
    n = 0;
    while (((m_tod / 60) % 60) != 0 && n < 60) begin press(0, 0, 1, 7, 7); n++; end
    chk("time_zeroed", 32'(disp_min_o), 0);
    press(1, 0, 0, 7, 7);
    press(0, 1, 0, 7, 7);
    chk("alarm_armed", 32'(alarm_en_o), 1);
    press(1, 0, 0, 7, 7);
    press(0, 0, 1, 7, 7);
    chk("alarm_min_shown", 32'(disp_min_o), 1);
    repeat (2) press(1, 0, 0, 7, 7);
    n = 0;
    while (m_ring == 0 && n < 2000) begin cyc(); n++; end
    chk("alarm_reached", 32'(n < 2000), 1);
    chk("alarm_rings", 32'(alarm_o), 1);
    chk("alarm_at_min1", 32'(disp_min_o), 1);
    chk("alarm_at_sec0", 32'(disp_sec_o), 0);
    repeat (3 * TD - 1) cyc();
    chk("alarm_still_on", 32'(alarm_o), 1);
    cyc();
    chk("alarm_timeout", 32'(alarm_o), 0);

    // Alarm silenced by btn_set in TIME
    repeat (4) press(1, 0, 0, 7, 7);
    press(0, 0, 1, 7, 7);
    repeat (2) press(1, 0, 0, 7, 7);
    n = 0;
    while (m_ring == 0 && n < 2000) begin cyc(); n++; end
    chk("alarm2_reached", 32'(n < 2000), 1);
    b_set = 1'b1;
    repeat (6) cyc();
    chk("silence_pending", 32'(alarm_o), 1);
    cyc();
    chk("silenced", 32'(alarm_o), 0);
    b_set = 1'b0;
    repeat (8) cyc();

    // Stopwatch
    repeat (5) press(1, 0, 0, 7, 7);
    chk("sw_mode", 32'(mode_o), 5);
    press(0, 1, 0, 7, 7);
    chk("sw_started", 32'(sw_run_o), 1);
    repeat (20 * TD) cyc();
    chk("sw_saturated", 32'(sw_count_o), 15);
    press(0, 0, 1, 7, 7);
    chk("sw_inc_ignored", 32'(sw_count_o), 15);
    press(0, 1, 0, 7, 7);
    press(0, 0, 1, 7, 7);
    chk("sw_cleared", 32'(sw_count_o), 0);

    // Asynchronous reset in SET_MIN
    repeat (3) press(1, 0, 0, 7, 7);
    n = 0;
    while (((m_tod / 60) % 60) != 7 && n < 60) begin press(0, 0, 1, 7, 7); n++; end
    chk("setmin_7", 32'(disp_min_o), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mode", 32'(mode_o), 0);
    chk("arst_min", 32'(disp_min_o), 0);
    chk("arst_hour", 32'(disp_hour_o), 0);
    chk("arst_alarm_en", 32'(alarm_en_o), 0);
    chk("arst_tick", 32'(tick_o), 0);
    model_reset();
    repeat (3) cyc();
    rst_n = 1'b1;

    // Randomized phase
    for (int it = 0; it < 250; it++) begin
      logic rm, rs, ri;
      rm = ($urandom_range(0, 4) == 0);
      rs = 1'($urandom_range(0, 1));
      ri = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) fmt12 = 1'($urandom_range(0, 1));
      press(rm, rs, ri, int'($urandom_range(1, 9)), int'($urandom_range(1, 9)));
      if ($urandom_range(0, 9) == 0) repeat (40) cyc();
      if (it == 125) begin
        async_reset();
        repeat (2) cyc();
        rst_n = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/watch_core_gen2.md
Name: watch_core_gen2

Overview:
Parametrised second-generation timekeeping core for the user project area.
- Keeps 24h time-of-day from a prescaled system clock.
- Adds a 12h/24h display mode, one settable alarm with auto-timeout, and a background stopwatch.
- Accepts three raw mechanical buttons, synchronised and debounced internally.
- Sits directly behind the user_project_wrapper pad mapping; the wrapper assigns these ports to io_in/io_out/io_oeb.

Parameters:
TICK_DIV, 10000000, clock cycles per one-second tick (>=2)
DEBOUNCE_CYC, 200000, cycles a synchronised button level must be stable before it is accepted (>=1)
ALARM_LEN_S, 30, seconds alarm_o stays asserted if not silenced (>=1)
SW_W, 16, stopwatch seconds counter width

Ports:
wb_clk_i  input  1  system clock
wb_rst_ni  input  1  asynchronous active-low reset
btn_mode_i  input  1  raw mode button, active-high, asynchronous
btn_set_i  input  1  raw set/action button, active-high, asynchronous
btn_inc_i  input  1  raw increment button, active-high, asynchronous
fmt12_i  input  1  1 = 12h display, 0 = 24h display (quasi-static, sampled directly)
disp_hour_o  output  5  displayed hour
disp_min_o  output  6  displayed minute
disp_sec_o  output  6  displayed second
pm_o  output  1  PM indicator (12h mode only, else 0)
mode_o  output  3  current FSM state encoding
alarm_en_o  output  1  alarm armed
alarm_o  output  1  alarm ringing
sw_run_o  output  1  stopwatch running
sw_count_o  output  SW_W  stopwatch seconds
tick_o  output  1  one-cycle pulse per second

Behaviour:
Clock and reset:
- All state is on the wb_clk_i rising edge, asynchronously cleared by wb_rst_ni=0.
- Reset values: all outputs 0; time 00:00:00; alarm time 00:00, disarmed; stopwatch stopped at 0; mode TIME (encoding 0).

Buttons:
- Each button passes through a 2-flop synchroniser, then a per-button debounce counter.
- The debounced level changes only after the synchronised level differs from it for DEBOUNCE_CYC consecutive cycles; any reversal restarts the count.
- A press event is a one-cycle pulse on the debounced rising edge. Release generates nothing.

Prescaler:
- Counts 0..TICK_DIV-1. tick_o=1 in the cycle the count equals TICK_DIV-1; the count then wraps to 0.
- Runs in every mode.

Time-of-day:
- Internal sec/min 0..59 and hour 0..23.
- On tick, sec increments; 59 wraps to 0 and carries to min; min 59 carries to hour; hour 23 wraps to 0.
- Time is frozen (ticks ignored) in SET_HOUR and SET_MIN.
- Entering SET_HOUR clears sec to 0.

Mode FSM:
- A btn_mode event advances TIME(0) -> SET_HOUR(1) -> SET_MIN(2) -> AL_HOUR(3) -> AL_MIN(4) -> STOPWATCH(5) -> TIME.
- SET_HOUR/SET_MIN: btn_inc increments hour (23->0) or min (59->0).
- AL_HOUR/AL_MIN: btn_inc increments the alarm hour/min with the same wraps; btn_set toggles alarm_en_o.
- STOPWATCH: btn_set toggles sw_run_o; btn_inc clears sw_count_o only when stopped and is ignored while running.
- TIME: btn_set silences a ringing alarm; btn_inc is ignored.
- Simultaneous events in one cycle: btn_mode wins and the other events that cycle are dropped.

Stopwatch:
- While sw_run_o=1, increments on each tick in every mode.
- Saturates at 2^SW_W-1; does not wrap.

Alarm:
- Triggers when alarm_en_o=1 and a tick moves time to alarm_hour:alarm_min:00.
- alarm_o rises in the same cycle the displayed time updates, i.e. registered with time.
- Once ringing, alarm_o clears on either:
  - ALARM_LEN_S further ticks, or
  - a btn_set event in TIME mode (alarm_o=0 the cycle after the event).
- Disarming alarm_en_o also clears alarm_o.
- No trigger while time is frozen. Re-trigger while ringing restarts the timeout.

Display:
- AL_HOUR/AL_MIN show the alarm hour/min, with sec=0.
- All other modes show time-of-day.
- fmt12_i=1 conversion:
  - hour 0 -> 12, pm 0
  - hour 1..11 -> same, pm 0
  - hour 12 -> 12, pm 1
  - hour 13..23 -> hour-12, pm 1
- fmt12_i=0: hour passes unchanged, pm_o=0.
- Display outputs are combinational from registered state.

Reset mid-operation: returns everything to reset values within the same cycle. In-progress debounce counts are discarded.

Test Plan:
(All scenarios use TICK_DIV=4, DEBOUNCE_CYC=4, ALARM_LEN_S=3, SW_W=4.)
1. Rollover: set 23:59 via buttons, return to TIME, apply 60 ticks -> disp 00:00:00, pm_o=0; next tick -> sec 1.
2. Debounce: btn_mode high 2 cycles then low -> mode_o stays 0. Held 10 cycles -> mode_o=1 exactly once. Simultaneous btn_mode+btn_inc in SET_HOUR -> mode_o=2, hour unchanged.
3. 12h format: hour 13 with fmt12_i=1 -> disp_hour_o=1, pm_o=1; hour 0 -> 12, pm_o=0; hour 12 -> 12, pm_o=1; fmt12_i=0 with hour 13 -> 13, pm_o=0.
4. Alarm: alarm 00:01 armed, time 00:00:00, TIME mode -> alarm_o=1 in the cycle min becomes 1; clears 3 ticks later. Repeat and press btn_set at the first tick -> alarm_o=0 one cycle after the event.
5. Stopwatch: start, 20 ticks -> sw_count_o=15 held; btn_inc while running -> stays 15; stop, btn_inc -> 0.
6. Reset mid-setting: in SET_MIN with min=7, assert wb_rst_ni=0 asynchronously -> all outputs 0 and mode_o=0 immediately, before the next clock edge.
